// File: rtl/dmi_pkg.sv
// Shared types and helpers for the DMI script driver.
package dmi_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    RESP_OK     = 2'd0,
    RESP_RSVD   = 2'd1,
    RESP_FAILED = 2'd2,
    RESP_BUSY   = 2'd3
  } dmi_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] REASON_RESP_FAIL      = 2'd1;
  localparam logic [1:0] REASON_BUSY_EXHAUSTED = 2'd2;
  localparam logic [1:0] REASON_COMPARE_FAIL   = 2'd3;

  localparam logic [31:0] EXIT_PASS = 32'd1;

  // Failure exit value: ((entry+1) + 256*reason) << 1 | 1, entry is zero-based.
  function automatic logic [31:0] exit_code(input logic [15:0] entry, input logic [1:0] reason);
    logic [31:0] code;
    code = 32'(entry) + 32'd1 + (32'(reason) << 8);
    return {code[30:0], 1'b1};
  endfunction

endpackage

// File: rtl/dmi_script_mem.sv
// Script storage: one write port, one combinational read port.
module dmi_script_mem #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [1:0]               wr_op,
  input  logic                     wr_poll,
  input  logic [ADDR_WIDTH-1:0]    wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [DATA_WIDTH-1:0]    wr_mask,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [1:0]               rd_op,
  output logic                     rd_poll,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    rd_mask
);

  logic [1:0]            op_mem   [DEPTH];
  logic                  poll_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DATA_WIDTH-1:0] mask_mem [DEPTH];

  // Entry write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      op_mem[wr_idx]   <= wr_op;
      poll_mem[wr_idx] <= wr_poll;
      addr_mem[wr_idx] <= wr_addr;
      data_mem[wr_idx] <= wr_data;
      mask_mem[wr_idx] <= wr_mask;
    end
  end

  assign rd_op   = op_mem[rd_idx];
  assign rd_poll = poll_mem[rd_idx];
  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];
  assign rd_mask = mask_mem[rd_idx];

endmodule

// File: rtl/dmi_script_driver.sv
// Replays a loaded DMI script over the req/resp handshake and reports via exit.
module dmi_script_driver
  import dmi_pkg::*;
#(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int RETRY_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   num_ops,
  input  logic                         load_en,
  input  logic [$clog2(DEPTH)-1:0]     load_idx,
  input  logic [1:0]                   load_op,
  input  logic                         load_poll,
  input  logic [ADDR_WIDTH-1:0]        load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data,
  input  logic [DATA_WIDTH-1:0]        load_mask,
  output logic                         debug_req_valid,
  input  logic                         debug_req_ready,
  output logic [ADDR_WIDTH-1:0]        debug_req_bits_addr,
  output logic [1:0]                   debug_req_bits_op,
  output logic [DATA_WIDTH-1:0]        debug_req_bits_data,
  input  logic                         debug_resp_valid,
  output logic                         debug_resp_ready,
  input  logic [1:0]                   debug_resp_bits_resp,
  input  logic [DATA_WIDTH-1:0]        debug_resp_bits_data,
  output logic                         busy,
  output logic [DATA_WIDTH-1:0]        last_rdata,
  output logic [31:0]                  exit
);

  localparam int NW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [RETRY_WIDTH-1:0] RETRY_LAST = {{(RETRY_WIDTH-1){1'b1}}, 1'b0};

  state_e                 state;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          last_idx;
  logic [RETRY_WIDTH-1:0] retry;
  dmi_op_e                cur_op;
  logic                   cur_poll;
  logic [DATA_WIDTH-1:0]  cur_data;
  logic [DATA_WIDTH-1:0]  cur_mask;

  logic [IW-1:0]          rd_idx;
  logic [1:0]             m_op;
  logic                   m_poll;
  logic [ADDR_WIDTH-1:0]  m_addr;
  logic [DATA_WIDTH-1:0]  m_data;
  logic [DATA_WIDTH-1:0]  m_mask;

  dmi_op_e                nxt_op;
  logic [DATA_WIDTH-1:0]  nxt_bus_data;
  logic [NW-1:0]          ops_clamped;
  logic [IW-1:0]          start_last;
  logic                   match;

  // The active entry lives in cur_* registers, so the read port can look ahead to idx+1.
  assign rd_idx = (state == ST_REQ || state == ST_RESP) ? idx + 1'b1 : '0;

  dmi_script_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (load_en && !busy),
    .wr_idx  (load_idx),
    .wr_op   (load_op),
    .wr_poll (load_poll),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .wr_mask (load_mask),
    .rd_idx  (rd_idx),
    .rd_op   (m_op),
    .rd_poll (m_poll),
    .rd_addr (m_addr),
    .rd_data (m_data),
    .rd_mask (m_mask)
  );

  // Decode the next entry's bus fields and the clamped run length.
  always_comb begin
    nxt_op       = (dmi_op_e'(m_op) == OP_RSVD) ? OP_NOP : dmi_op_e'(m_op);
    nxt_bus_data = (nxt_op == OP_WRITE) ? m_data : '0;
    ops_clamped  = (num_ops > NW'(DEPTH)) ? NW'(DEPTH) : num_ops;
    start_last   = IW'(ops_clamped - 1'b1);
    match        = ((debug_resp_bits_data & cur_mask) == (cur_data & cur_mask));
  end

  // Script sequencer with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      debug_req_valid     <= 1'b0;
      debug_resp_ready    <= 1'b0;
      debug_req_bits_addr <= '0;
      debug_req_bits_op   <= '0;
      debug_req_bits_data <= '0;
      busy                <= 1'b0;
      last_rdata          <= '0;
      exit                <= '0;
      idx                 <= '0;
      last_idx            <= '0;
      retry               <= '0;
      cur_op              <= OP_NOP;
      cur_poll            <= 1'b0;
      cur_data            <= '0;
      cur_mask            <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            exit  <= '0;
            retry <= '0;
            idx   <= '0;
            if (num_ops == '0) begin
              state <= ST_DONE;
              exit  <= EXIT_PASS;
            end else begin
              state               <= ST_REQ;
              busy                <= 1'b1;
              last_idx            <= start_last;
              debug_req_valid     <= 1'b1;
              debug_req_bits_addr <= m_addr;
              debug_req_bits_op   <= nxt_op;
              debug_req_bits_data <= nxt_bus_data;
              cur_op              <= nxt_op;
              cur_poll            <= m_poll;
              cur_data            <= m_data;
              cur_mask            <= m_mask;
            end
          end
        end

        ST_REQ: begin
          if (debug_req_ready) begin
            debug_req_valid  <= 1'b0;
            debug_resp_ready <= 1'b1;
            state            <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (debug_resp_valid) begin
            debug_resp_ready <= 1'b0;
            case (dmi_resp_e'(debug_resp_bits_resp))
              RESP_BUSY: begin
                if (retry == RETRY_LAST) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  exit  <= exit_code(16'(idx), REASON_BUSY_EXHAUSTED);
                end else begin
                  retry           <= retry + 1'b1;
                  debug_req_valid <= 1'b1;
                  state           <= ST_REQ;
                end
              end
              RESP_FAILED, RESP_RSVD: begin
                state <= ST_DONE;
                busy  <= 1'b0;
                exit  <= exit_code(16'(idx), REASON_RESP_FAIL);
              end
              default: begin
                if (cur_op == OP_READ) begin
                  last_rdata <= debug_resp_bits_data;
                end
                if (cur_op == OP_READ && !match) begin
                  if (cur_poll && retry != RETRY_LAST) begin
                    retry           <= retry + 1'b1;
                    debug_req_valid <= 1'b1;
                    state           <= ST_REQ;
                  end else begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    exit  <= exit_code(16'(idx), REASON_COMPARE_FAIL);
                  end
                end else begin
                  retry <= '0;
                  if (idx == last_idx) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    exit  <= EXIT_PASS;
                  end else begin
                    idx                 <= idx + 1'b1;
                    state               <= ST_REQ;
                    debug_req_valid     <= 1'b1;
                    debug_req_bits_addr <= m_addr;
                    debug_req_bits_op   <= nxt_op;
                    debug_req_bits_data <= nxt_bus_data;
                    cur_op              <= nxt_op;
                    cur_poll            <= m_poll;
                    cur_data            <= m_data;
                    cur_mask            <= m_mask;
                  end
                end
              end
            endcase
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_script_driver.sv
// Directed bench for dmi_script_driver: table of scripted runs plus corner sequences.
module tb_dmi_script_driver;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  num_ops;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [1:0]  load_op;
  logic        load_poll;
  logic [6:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] load_mask;
  logic        debug_req_valid;
  logic        debug_req_ready;
  logic [6:0]  debug_req_bits_addr;
  logic [1:0]  debug_req_bits_op;
  logic [31:0] debug_req_bits_data;
  logic        debug_resp_valid;
  logic        debug_resp_ready;
  logic [1:0]  debug_resp_bits_resp;
  logic [31:0] debug_resp_bits_data;
  logic        busy;
  logic [31:0] last_rdata;
  logic [31:0] exit_val;

  int tests = 0;
  int fails = 0;

  dmi_script_driver #(
    .ADDR_WIDTH  (7),
    .DATA_WIDTH  (32),
    .DEPTH       (4),
    .RETRY_WIDTH (2)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .num_ops              (num_ops),
    .load_en              (load_en),
    .load_idx             (load_idx),
    .load_op              (load_op),
    .load_poll            (load_poll),
    .load_addr            (load_addr),
    .load_data            (load_data),
    .load_mask            (load_mask),
    .debug_req_valid      (debug_req_valid),
    .debug_req_ready      (debug_req_ready),
    .debug_req_bits_addr  (debug_req_bits_addr),
    .debug_req_bits_op    (debug_req_bits_op),
    .debug_req_bits_data  (debug_req_bits_data),
    .debug_resp_valid     (debug_resp_valid),
    .debug_resp_ready     (debug_resp_ready),
    .debug_resp_bits_resp (debug_resp_bits_resp),
    .debug_resp_bits_data (debug_resp_bits_data),
    .busy                 (busy),
    .last_rdata           (last_rdata),
    .exit                 (exit_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0][1:0]  op;
    logic [3:0]       poll;
    logic [3:0][6:0]  addr;
    logic [3:0][31:0] data;
    logic [3:0][31:0] mask;
    logic [2:0]       n_ops;
    int               n_rsp;
    logic [7:0][1:0]  rsp;
    logic [7:0][31:0] rdat;
    int               exp_reqs;
    logic [7:0][6:0]  exp_addr;
    logic [7:0][1:0]  exp_op;
    logic [31:0]      exp_exit;
    logic [31:0]      exp_last;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t vblank();
    vec_t v;
    v.op = '0; v.poll = '0; v.addr = '0; v.data = '0; v.mask = '0;
    v.n_ops = '0; v.n_rsp = 0; v.rsp = '0; v.rdat = '0;
    v.exp_reqs = 0; v.exp_addr = '0; v.exp_op = '0;
    v.exp_exit = '0; v.exp_last = '0;
    return v;
  endfunction

  function automatic vec_t ent(input vec_t v, input int e, input logic [1:0] op, input logic poll,
                               input logic [6:0] a, input logic [31:0] d, input logic [31:0] m);
    v.op[e] = op; v.poll[e] = poll; v.addr[e] = a; v.data[e] = d; v.mask[e] = m;
    return v;
  endfunction

  function automatic vec_t rsp(input vec_t v, input logic [1:0] r, input logic [31:0] d);
    v.rsp[v.n_rsp] = r; v.rdat[v.n_rsp] = d; v.n_rsp++;
    return v;
  endfunction

  function automatic vec_t ereq(input vec_t v, input logic [6:0] a, input logic [1:0] op);
    v.exp_addr[v.exp_reqs] = a; v.exp_op[v.exp_reqs] = op; v.exp_reqs++;
    return v;
  endfunction

  function automatic vec_t fin(input vec_t v, input logic [2:0] n, input logic [31:0] ex, input logic [31:0] last);
    v.n_ops = n; v.exp_exit = ex; v.exp_last = last;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_entry(input logic [1:0] i, input logic [1:0] op, input logic poll,
                            input logic [6:0] a, input logic [31:0] d, input logic [31:0] m);
    load_en = 1'b1; load_idx = i; load_op = op; load_poll = poll;
    load_addr = a; load_data = d; load_mask = m;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [2:0] n);
    start = 1'b1; num_ops = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accept the pending request and answer it with a success response.
  task automatic serve_ok(input logic [31:0] d);
    debug_req_ready = 1'b1;
    @(negedge clk);
    debug_req_ready = 1'b0;
    debug_resp_valid = 1'b1; debug_resp_bits_resp = 2'd0; debug_resp_bits_data = d;
    @(negedge clk);
    debug_resp_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int reqs;
    int n;
    int ph;
    bit done;
    do_reset();
    for (int e = 0; e < 4; e++)
      load_entry(2'(e), v.op[e], v.poll[e], v.addr[e], v.data[e], v.mask[e]);
    pulse_start(v.n_ops);
    reqs = 0; n = 0; ph = 0; done = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (ph == 0) begin
        if (debug_req_valid) begin
          if (reqs < v.exp_reqs) begin
            check($sformatf("v%0d req%0d addr", k, reqs), 32'(debug_req_bits_addr), 32'(v.exp_addr[reqs]));
            check($sformatf("v%0d req%0d op", k, reqs), 32'(debug_req_bits_op), 32'(v.exp_op[reqs]));
          end
          reqs++;
          debug_req_ready = 1'b1;
          ph = 1;
        end else if (!busy) begin
          done = 1;
        end
      end else if (ph == 1) begin
        debug_req_ready = 1'b0;
        debug_resp_valid = 1'b1;
        debug_resp_bits_resp = (n < 8) ? v.rsp[n] : 2'd0;
        debug_resp_bits_data = (n < 8) ? v.rdat[n] : 32'd0;
        ph = 2;
      end else begin
        debug_resp_valid = 1'b0;
        n++;
        ph = 0;
      end
      if (!done) @(negedge clk);
    end
    debug_req_ready = 1'b0;
    debug_resp_valid = 1'b0;
    check($sformatf("v%0d completion", k), 32'(done), 32'd1);
    check($sformatf("v%0d request count", k), reqs, v.exp_reqs);
    check($sformatf("v%0d exit", k), exit_val, v.exp_exit);
    check($sformatf("v%0d last_rdata", k), last_rdata, v.exp_last);
    check($sformatf("v%0d busy", k), 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; num_ops = '0;
    load_en = 1'b0; load_idx = '0; load_op = '0; load_poll = 1'b0;
    load_addr = '0; load_data = '0; load_mask = '0;
    debug_req_ready = 1'b0; debug_resp_valid = 1'b0;
    debug_resp_bits_resp = '0; debug_resp_bits_data = '0;

    // write then masked read
    v = vblank(); v = ent(v, 0, 2, 0, 7'h10, 32'h1, 32'h0); v = ent(v, 1, 1, 0, 7'h11, 32'h3, 32'hF);
    v = rsp(v, 0, 0); v = rsp(v, 0, 32'h3);
    v = ereq(v, 7'h10, 2); v = ereq(v, 7'h11, 1); vt[0] = fin(v, 2, 32'd1, 32'h3);
    // two busies then success
    v = vblank(); v = ent(v, 0, 2, 0, 7'h10, 32'h5, 32'h0);
    v = rsp(v, 3, 0); v = rsp(v, 3, 0); v = rsp(v, 0, 0);
    v = ereq(v, 7'h10, 2); v = ereq(v, 7'h10, 2); v = ereq(v, 7'h10, 2); vt[1] = fin(v, 1, 32'd1, 32'h0);
    // busy exhausted on third attempt: code 1+512=513
    v = vblank(); v = ent(v, 0, 2, 0, 7'h10, 32'h5, 32'h0);
    v = rsp(v, 3, 0); v = rsp(v, 3, 0); v = rsp(v, 3, 0); v = rsp(v, 3, 0);
    v = ereq(v, 7'h10, 2); v = ereq(v, 7'h10, 2); v = ereq(v, 7'h10, 2); vt[2] = fin(v, 1, 32'd1027, 32'h0);
    // poll until bit0 set
    v = vblank(); v = ent(v, 0, 1, 1, 7'h11, 32'h1, 32'h1);
    v = rsp(v, 0, 0); v = rsp(v, 0, 0); v = rsp(v, 0, 32'h1);
    v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); vt[3] = fin(v, 1, 32'd1, 32'h1);
    // poll exhausted: code 1+768=769
    v = vblank(); v = ent(v, 0, 1, 1, 7'h11, 32'h1, 32'h1);
    v = rsp(v, 0, 0); v = rsp(v, 0, 0); v = rsp(v, 0, 0);
    v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); vt[4] = fin(v, 1, 32'd1539, 32'h0);
    // no poll, immediate compare fail
    v = vblank(); v = ent(v, 0, 1, 0, 7'h11, 32'h1, 32'h1);
    v = rsp(v, 0, 0); v = ereq(v, 7'h11, 1); vt[5] = fin(v, 1, 32'd1539, 32'h0);
    // resp failed on second of three writes: code 2+256=258
    v = vblank(); v = ent(v, 0, 2, 0, 7'h20, 32'h1, 0); v = ent(v, 1, 2, 0, 7'h21, 32'h2, 0);
    v = ent(v, 2, 2, 0, 7'h22, 32'h3, 0);
    v = rsp(v, 0, 0); v = rsp(v, 2, 0);
    v = ereq(v, 7'h20, 2); v = ereq(v, 7'h21, 2); vt[6] = fin(v, 3, 32'd517, 32'h0);
    // num_ops clamped to DEPTH; reserved op goes out as nop
    v = vblank(); v = ent(v, 0, 0, 0, 7'h30, 0, 0); v = ent(v, 1, 3, 0, 7'h31, 0, 0);
    v = ent(v, 2, 0, 0, 7'h32, 0, 0); v = ent(v, 3, 0, 0, 7'h33, 0, 0);
    v = rsp(v, 0, 0); v = rsp(v, 0, 0); v = rsp(v, 0, 0); v = rsp(v, 0, 0);
    v = ereq(v, 7'h30, 0); v = ereq(v, 7'h31, 0); v = ereq(v, 7'h32, 0); v = ereq(v, 7'h33, 0);
    vt[7] = fin(v, 7, 32'd1, 32'h0);
    // reserved resp code counts as failure: code 257
    v = vblank(); v = ent(v, 0, 2, 0, 7'h10, 32'h9, 0);
    v = rsp(v, 1, 0); v = ereq(v, 7'h10, 2); vt[8] = fin(v, 1, 32'd515, 32'h0);
    // zero mask disables compare
    v = vblank(); v = ent(v, 0, 1, 0, 7'h12, 32'h12345678, 32'h0);
    v = rsp(v, 0, 32'hDEADBEEF); v = ereq(v, 7'h12, 1); vt[9] = fin(v, 1, 32'd1, 32'hDEADBEEF);
    // busy and poll share one counter
    v = vblank(); v = ent(v, 0, 1, 1, 7'h11, 32'h1, 32'h1);
    v = rsp(v, 3, 0); v = rsp(v, 0, 0); v = rsp(v, 0, 0);
    v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); v = ereq(v, 7'h11, 1); vt[10] = fin(v, 1, 32'd1539, 32'h0);
    // nop, masked-high-nibble read, write
    v = vblank(); v = ent(v, 0, 0, 0, 7'h40, 0, 0); v = ent(v, 1, 1, 0, 7'h41, 32'hA0, 32'hF0);
    v = ent(v, 2, 2, 0, 7'h42, 32'h77, 0);
    v = rsp(v, 0, 0); v = rsp(v, 0, 32'hAB); v = rsp(v, 0, 0);
    v = ereq(v, 7'h40, 0); v = ereq(v, 7'h41, 1); v = ereq(v, 7'h42, 2); vt[11] = fin(v, 3, 32'd1, 32'hAB);

    // Reset state, and no response acceptance while idle
    do_reset();
    debug_resp_valid = 1'b1;
    @(negedge clk);
    check("rst req_valid", 32'(debug_req_valid), 32'd0);
    check("rst resp_ready", 32'(debug_resp_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst exit", exit_val, 32'd0);
    check("rst last_rdata", last_rdata, 32'd0);
    check("rst addr", 32'(debug_req_bits_addr), 32'd0);
    check("rst op", 32'(debug_req_bits_op), 32'd0);
    check("rst data", debug_req_bits_data, 32'd0);
    debug_resp_valid = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(vt[k], k);

    // Stall with ready low: request fields stable, loads while busy ignored
    do_reset();
    load_entry(2'd0, 2'd2, 1'b0, 7'h15, 32'hCAFE, 32'h0);
    pulse_start(3'd1);
    check("stall valid after start", 32'(debug_req_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        load_en = 1'b1; load_idx = 2'd0; load_op = 2'd2;
        load_addr = 7'h7F; load_data = 32'hBAD; load_mask = 32'h0;
      end else begin
        load_en = 1'b0;
      end
      check($sformatf("stall%0d valid", i), 32'(debug_req_valid), 32'd1);
      check($sformatf("stall%0d addr", i), 32'(debug_req_bits_addr), 32'h15);
      check($sformatf("stall%0d op", i), 32'(debug_req_bits_op), 32'd2);
      check($sformatf("stall%0d data", i), debug_req_bits_data, 32'hCAFE);
      check($sformatf("stall%0d resp_ready", i), 32'(debug_resp_ready), 32'd0);
      @(negedge clk);
    end
    load_en = 1'b0;
    serve_ok(32'h0);
    check("stall exit", exit_val, 32'd1);
    pulse_start(3'd1);
    check("busy-load ignored addr", 32'(debug_req_bits_addr), 32'h15);
    check("busy-load ignored data", debug_req_bits_data, 32'hCAFE);
    serve_ok(32'h0);
    check("rerun exit", exit_val, 32'd1);

    // Reset while waiting for a response, then replay and zero-length run
    load_entry(2'd0, 2'd1, 1'b0, 7'h11, 32'h5, 32'hF);
    pulse_start(3'd1);
    check("read req op", 32'(debug_req_bits_op), 32'd1);
    check("read req data zero", debug_req_bits_data, 32'd0);
    debug_req_ready = 1'b1;
    @(negedge clk);
    debug_req_ready = 1'b0;
    check("resp state ready", 32'(debug_resp_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-reset valid", 32'(debug_req_valid), 32'd0);
    check("mid-reset resp_ready", 32'(debug_resp_ready), 32'd0);
    check("mid-reset exit", exit_val, 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    pulse_start(3'd1);
    check("replay addr", 32'(debug_req_bits_addr), 32'h11);
    serve_ok(32'h5);
    check("replay exit", exit_val, 32'd1);
    check("replay last_rdata", last_rdata, 32'h5);
    pulse_start(3'd1);
    check("start clears exit", exit_val, 32'd0);
    serve_ok(32'h15);
    check("second replay exit", exit_val, 32'd1);
    check("second replay last_rdata", last_rdata, 32'h15);
    pulse_start(3'd0);
    check("zero ops exit", exit_val, 32'd1);
    check("zero ops busy", 32'(busy), 32'd0);
    check("zero ops valid", 32'(debug_req_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
